// File: rtl/main_package.sv
// Shared types and constants for the layer compositor: FSM state encoding,
// RGB444 field positions and the default number of element slots.
package main_package;

    localparam int Rend_number = 4;

    // RGB444 pixel layout: {R[3:0], G[3:0], B[3:0]}
    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BG     = 3'd1,
        S_SEL    = 3'd2,
        S_EL_RUN = 3'd3,
        S_EL_END = 3'd4,
        S_FLUSH  = 3'd5,
        S_DONE   = 3'd6
    } compositor_state_t;

endpackage

// File: rtl/compositor_out_stage.sv
// Framebuffer output register: one write slot that reloads when empty or when
// the current write is taken, and asks the painters to freeze while stalled.
module compositor_out_stage #(
    parameter int COOR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ld_i,
    input  logic [11:0]           data_i,
    input  logic [COOR_WIDTH-1:0] x_i,
    input  logic [COOR_WIDTH-1:0] y_i,
    input  logic                  fb_ready_i,
    output logic                  fb_we_o,
    output logic [11:0]           fb_data_o,
    output logic [COOR_WIDTH-1:0] fb_x_o,
    output logic [COOR_WIDTH-1:0] fb_y_o,
    output logic                  src_hold_o
);

    logic                  we_q, we_d;
    logic [11:0]           data_q, data_d;
    logic [COOR_WIDTH-1:0] x_q, x_d;
    logic [COOR_WIDTH-1:0] y_q, y_d;
    logic                  can_load;

    assign can_load = !we_q || fb_ready_i;

    always_comb begin
        we_d   = we_q;
        data_d = data_q;
        x_d    = x_q;
        y_d    = y_q;
        if (can_load) begin
            we_d = ld_i;
            if (ld_i) begin
                data_d = data_i;
                x_d    = x_i;
                y_d    = y_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            data_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            we_q   <= we_d;
            data_q <= data_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign fb_we_o    = we_q;
    assign fb_data_o  = data_q;
    assign fb_x_o     = x_q;
    assign fb_y_o     = y_q;
    assign src_hold_o = we_q & ~fb_ready_i;

endmodule

// File: rtl/layer_compositor.sv
// Frame sequencer: background pass, then each enabled element in index order,
// into a backpressured framebuffer port. Chroma keying with LAYER_COMPOSITOR_CHROMA_KEY_EN.
module layer_compositor
    import main_package::*;
#(
    parameter int         N_ELEM     = Rend_number,
    parameter int         COOR_WIDTH = 12,
    parameter logic [3:0] KEY_G_MIN  = 4'h9,
    parameter logic [3:0] KEY_RB_MAX = 4'h9,
    parameter int         IDX_W      = $clog2(N_ELEM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_ELEM-1:0]     elem_en,
    output logic                  bg_rst,
    input  logic                  bg_valid,
    input  logic                  bg_done,
    input  logic [11:0]           bg_pixel,
    input  logic [COOR_WIDTH-1:0] bg_x,
    input  logic [COOR_WIDTH-1:0] bg_y,
    output logic [IDX_W-1:0]      el_idx,
    output logic                  el_rst,
    input  logic                  el_valid,
    input  logic                  el_done,
    input  logic [11:0]           el_pixel,
    input  logic [COOR_WIDTH-1:0] el_x,
    input  logic [COOR_WIDTH-1:0] el_y,
    output logic                  src_hold,
    output logic                  fb_we,
    output logic [11:0]           fb_data,
    output logic [COOR_WIDTH-1:0] fb_x,
    output logic [COOR_WIDTH-1:0] fb_y,
    input  logic                  fb_ready,
    output logic                  busy,
    output logic                  done
);

`ifdef LAYER_COMPOSITOR_CHROMA_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    compositor_state_t     state_q;
    logic [N_ELEM-1:0]     en_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  bg_rst_q, el_rst_q, busy_q, done_q;

    logic                  bg_acc, el_acc, key_hit, el_wr, last_idx, ld;
    logic [11:0]           ld_data;
    logic [COOR_WIDTH-1:0] ld_x, ld_y;

    assign bg_acc   = (state_q == S_BG) && bg_valid && !src_hold;
    assign el_acc   = (state_q == S_EL_RUN) && el_valid && !src_hold;
    assign key_hit  = (el_pixel[G_HI:G_LO] >= KEY_G_MIN) &&
                      (el_pixel[R_HI:R_LO] <  KEY_RB_MAX) &&
                      (el_pixel[B_HI:B_LO] <  KEY_RB_MAX);
    // A keyed pixel is still consumed so its done flag can end the pass.
    assign el_wr    = el_acc && !(KEY_EN && key_hit);
    assign last_idx = (idx_q == IDX_W'(N_ELEM - 1));
    assign ld       = bg_acc || el_wr;
    assign ld_data  = (state_q == S_BG) ? bg_pixel : el_pixel;
    assign ld_x     = (state_q == S_BG) ? bg_x : el_x;
    assign ld_y     = (state_q == S_BG) ? bg_y : el_y;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            en_q     <= '0;
            idx_q    <= '0;
            bg_rst_q <= 1'b1;
            el_rst_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        en_q     <= elem_en;
                        idx_q    <= '0;
                        bg_rst_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_BG;
                    end
                end
                S_BG: begin
                    if (bg_acc && bg_done) begin
                        bg_rst_q <= 1'b1;
                        state_q  <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (en_q[idx_q]) begin
                        el_rst_q <= 1'b0;
                        state_q  <= S_EL_RUN;
                    end else if (last_idx) begin
                        state_q <= S_FLUSH;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_EL_RUN: begin
                    if (el_acc && el_done) begin
                        el_rst_q <= 1'b1;
                        state_q  <= S_EL_END;
                    end
                end
                S_EL_END: begin
                    if (last_idx) begin
                        state_q <= S_FLUSH;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_SEL;
                    end
                end
                S_FLUSH: begin
                    if (!fb_we) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    compositor_out_stage #(
        .COOR_WIDTH(COOR_WIDTH)
    ) u_out (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .ld_i       (ld),
        .data_i     (ld_data),
        .x_i        (ld_x),
        .y_i        (ld_y),
        .fb_ready_i (fb_ready),
        .fb_we_o    (fb_we),
        .fb_data_o  (fb_data),
        .fb_x_o     (fb_x),
        .fb_y_o     (fb_y),
        .src_hold_o (src_hold)
    );

    assign bg_rst = bg_rst_q;
    assign el_rst = el_rst_q;
    assign el_idx = idx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: queue-based painters and a frame-level model of
// the expected framebuffer write sequence.
module tb_layer_compositor;

    localparam int N  = 4;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n, start, bg_valid, bg_done, el_valid, el_done, fb_ready;
    logic [N-1:0]  elem_en;
    logic [11:0]   bg_pixel, el_pixel, fb_data;
    logic [CW-1:0] bg_x, bg_y, el_x, el_y, fb_x, fb_y;
    logic [1:0]    el_idx;
    logic          bg_rst, el_rst, src_hold, fb_we, busy, done;

    always #5 clk = ~clk;

    layer_compositor #(.N_ELEM(N), .COOR_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .elem_en(elem_en),
        .bg_rst(bg_rst), .bg_valid(bg_valid), .bg_done(bg_done), .bg_pixel(bg_pixel),
        .bg_x(bg_x), .bg_y(bg_y), .el_idx(el_idx), .el_rst(el_rst),
        .el_valid(el_valid), .el_done(el_done), .el_pixel(el_pixel),
        .el_x(el_x), .el_y(el_y), .src_hold(src_hold), .fb_we(fb_we),
        .fb_data(fb_data), .fb_x(fb_x), .fb_y(fb_y), .fb_ready(fb_ready),
        .busy(busy), .done(done)
    );

    // painter contents
    logic [11:0]   bg_pix[16];
    logic [CW-1:0] bg_xs[16], bg_ys[16];
    int            bg_len;
    logic [11:0]   el_pix[N][16];
    logic [CW-1:0] el_xs[N][16], el_ys[N][16];
    int            el_len[N];

    int  bg_ptr, el_ptr;
    bit  bg_pend, el_pend;
    logic [35:0] obs_q[$], exp_q[$];
    int  exp_order[$], run_order[$];
    int  n_assert = 0, n_fail = 0;
    int  done_cnt, busy_bad, stab_bad, hold_bad, hold_hi, idle_cyc, stall_left, rdy_mode;
    bit  stalled_once, start_next, prev_hold, prev_el_rst;
    logic [35:0] prev_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_key(input logic [11:0] p);
        int r, g, b;
        r = (p >> 8) & 15;
        g = (p >> 4) & 15;
        b = p & 15;
`ifdef LAYER_COMPOSITOR_CHROMA_KEY_EN
        return (g >= 9) && (r < 9) && (b < 9);
`else
        return (r + g + b) < 0;
`endif
    endfunction

    task automatic check_reset(input string t);
        chk({t, "_bg_rst"}, bg_rst, 1);
        chk({t, "_el_rst"}, el_rst, 1);
        chk({t, "_el_idx"}, el_idx, 0);
        chk({t, "_src_hold"}, src_hold, 0);
        chk({t, "_fb_we"}, fb_we, 0);
        chk({t, "_fb_out"}, {fb_data, fb_x, fb_y}, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, 0);
    endtask

    task automatic step();
        bit bg_acc, el_acc;
        int k;
        @(negedge clk);
        if (rdy_mode == 2 && !stalled_once && !el_rst && fb_we) begin
            stalled_once = 1;
            stall_left   = 5;
        end
        if (rdy_mode == 0) fb_ready = 1'b1;
        else if (rdy_mode == 1) fb_ready = ($urandom_range(0, 3) != 0);
        else begin
            fb_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
        end
        if (bg_rst) begin
            bg_ptr = 0; bg_pend = 0; bg_valid = 1'b0;
        end else if (bg_ptr < bg_len) begin
            bg_valid = bg_pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            bg_pixel = bg_pix[bg_ptr]; bg_x = bg_xs[bg_ptr]; bg_y = bg_ys[bg_ptr];
            bg_done  = (bg_ptr == bg_len - 1);
        end else bg_valid = 1'b0;
        k = int'(el_idx);
        if (el_rst) begin
            el_ptr = 0; el_pend = 0; el_valid = 1'b0;
        end else if (el_ptr < el_len[k]) begin
            el_valid = el_pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            el_pixel = el_pix[k][el_ptr]; el_x = el_xs[k][el_ptr]; el_y = el_ys[k][el_ptr];
            el_done  = (el_ptr == el_len[k] - 1);
        end else el_valid = 1'b0;
        start = start_next;
        start_next = 0;
        #1;
        if (fb_we && fb_ready) obs_q.push_back({fb_data, fb_x, fb_y});
        bg_acc  = bg_valid && !src_hold && !bg_rst;
        bg_pend = bg_valid && !bg_acc;
        if (bg_acc) bg_ptr++;
        el_acc  = el_valid && !src_hold && !el_rst;
        el_pend = el_valid && !el_acc;
        if (el_acc) el_ptr++;
        if (done) done_cnt++;
        if (done && busy) busy_bad++;
        if (busy && bg_rst && el_rst) idle_cyc++;
        if (src_hold) hold_hi++;
        if (src_hold !== (fb_we & ~fb_ready)) hold_bad++;
        if (prev_hold && (fb_we !== 1'b1 || {fb_data, fb_x, fb_y} !== prev_out)) stab_bad++;
        prev_hold = fb_we && !fb_ready;
        prev_out  = {fb_data, fb_x, fb_y};
        if (!el_rst && prev_el_rst) run_order.push_back(int'(el_idx));
        prev_el_rst = el_rst;
    endtask

    task automatic fill_random();
        bg_len = 6;
        for (int i = 0; i < 16; i++) begin
            bg_pix[i] = 12'($urandom); bg_xs[i] = CW'($urandom); bg_ys[i] = CW'($urandom);
        end
        for (int e = 0; e < N; e++) begin
            el_len[e] = $urandom_range(1, 6);
            for (int i = 0; i < 16; i++) begin
                el_pix[e][i] = 12'($urandom); el_xs[e][i] = CW'($urandom); el_ys[e][i] = CW'($urandom);
            end
        end
    endtask

    task automatic run_frame(input string t, input logic [N-1:0] en, input bit dbl);
        int cyc, m;
        logic [N-1:0] env;
        env = en;
        obs_q.delete(); exp_q.delete(); exp_order.delete(); run_order.delete();
        done_cnt = 0; busy_bad = 0; stab_bad = 0; hold_bad = 0; hold_hi = 0; idle_cyc = 0;
        prev_hold = 0; prev_el_rst = 1; stall_left = 0;
        for (int i = 0; i < bg_len; i++) exp_q.push_back({bg_pix[i], bg_xs[i], bg_ys[i]});
        for (int e = 0; e < N; e++) begin
            if (env[e]) begin
                exp_order.push_back(e);
                for (int i = 0; i < el_len[e]; i++)
                    if (!is_key(el_pix[e][i])) exp_q.push_back({el_pix[e][i], el_xs[e][i], el_ys[e][i]});
            end
        end
        elem_en = en;
        start_next = 1;
        step();
        step();
        chk({t, "_busy_rise"}, busy, 1);
        if (dbl) begin
            step();
            chk({t, "_in_bg"}, bg_rst, 0);
            start_next = 1;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin step(); cyc++; end
        chk({t, "_no_timeout"}, (done_cnt > 0), 1);
        repeat (4) step();
        chk({t, "_done_once"}, done_cnt, 1);
        chk({t, "_busy_low_at_done"}, busy_bad, 0);
        chk({t, "_hold_rule"}, hold_bad, 0);
        chk({t, "_stable_when_held"}, stab_bad, 0);
        chk({t, "_n_writes"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk({t, "_write"}, obs_q[i], exp_q[i]);
        chk({t, "_n_passes"}, run_order.size(), exp_order.size());
        m = (run_order.size() < exp_order.size()) ? run_order.size() : exp_order.size();
        for (int i = 0; i < m; i++) chk({t, "_pass_idx"}, run_order[i], exp_order[i]);
    endtask

    initial begin
        int cyc;
        rst_n = 1; start = 0; start_next = 0; elem_en = '0; fb_ready = 1;
        bg_valid = 0; bg_done = 0; bg_pixel = '0; bg_x = '0; bg_y = '0;
        el_valid = 0; el_done = 0; el_pixel = '0; el_x = '0; el_y = '0;
        rdy_mode = 0; stalled_once = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 0;

        fill_random();
        rdy_mode = 0;
        run_frame("bg_only", 4'b0000, 0);
        chk("bg_only_sel_flush_cycles", idle_cyc, N + 1);

        fill_random();
        rdy_mode = 1;
        run_frame("order", 4'b1010, 0);

        fill_random();
        el_len[1] = 3;
        el_pix[1][0] = 12'h0F0; el_pix[1][1] = 12'h2A1; el_pix[1][2] = 12'hAF0;
        rdy_mode = 0;
        run_frame("key", 4'b0010, 0);

        fill_random();
        el_len[0] = 8; el_len[2] = 8;
        rdy_mode = 2; stalled_once = 0;
        run_frame("bp", 4'b0101, 0);
        chk("bp_hold_cycles", hold_hi, 5);

        fill_random();
        el_len[1] = 10;
        rdy_mode = 1;
        elem_en = 4'b1010;
        start_next = 1;
        prev_el_rst = 1;
        cyc = 0;
        while (!(!el_rst && el_idx == 2'd1) && cyc < 500) begin step(); cyc++; end
        chk("midrst_reached_el1", (!el_rst && el_idx == 2'd1), 1);
        step();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst_n = 0;
        done_cnt = 0; prev_hold = 0;
        repeat (10) step();
        chk("midrst_no_done", done_cnt, 0);
        run_frame("after_rst", 4'b1010, 0);

        fill_random();
        rdy_mode = 1;
        run_frame("dbl_start", 4'b1111, 1);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_frame("rand", N'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
